qam_mapper_multi: RTL and testbench

//  Parametrised, mode-selectable Gray-coded constellation mapper (BPSK/QPSK/16-QAM/64-QAM).

---
 rtl/qam_mapper_multi_if.sv | 29 ++
 rtl/qam_mapper_multi.sv | 132 +++++++++++++
 tb/tb_qam_mapper_multi.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_mapper_multi_if.sv
// Stream bundle for the constellation mapper.
//   mode/sym_in/s_valid/s_last/s_ready : symbol input stream
//   out_r/out_i/m_valid/m_last/m_ready : I/Q sample output stream
// slave  : mapper side (consumes symbols, produces samples)
// master : surrounding logic side (produces symbols, consumes samples)
interface qam_mapper_multi_if #(
    parameter int unsigned OUT_W = 16
);
    logic [1:0]              mode;
    logic [5:0]              sym_in;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic signed [OUT_W-1:0] out_r;
    logic signed [OUT_W-1:0] out_i;
    logic                    m_valid;
    logic                    m_last;
    logic                    m_ready;

    modport master (
        output mode, sym_in, s_valid, s_last, m_ready,
        input  s_ready, out_r, out_i, m_valid, m_last
    );

    modport slave (
        input  mode, sym_in, s_valid, s_last, m_ready,
        output s_ready, out_r, out_i, m_valid, m_last
    );
endinterface

// File: rtl/qam_mapper_multi.sv
// Mode-selectable Gray-coded constellation mapper (BPSK/QPSK/16-QAM/64-QAM).
// Two-stage stallable pipeline: stage 1 decodes Gray bits into odd integer
// levels, stage 2 scales them by the per-mode normalised step.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of the symbol-in / sample-out stream bundle
//   sym_cnt  : count of completed output handshakes, wraps modulo 2^CNT_W
module qam_mapper_multi #(
    parameter int unsigned OUT_W     = 16,
    parameter int          STEP_BPSK = 16384,
    parameter int          STEP_QPSK = 11585,
    parameter int          STEP_16   = 5181,
    parameter int          STEP_64   = 2528,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    qam_mapper_multi_if.slave  bus,
    output logic [CNT_W-1:0]   sym_cnt
);

    // One Gray bit -> -1/+1
    function automatic logic signed [3:0] lvl1(input logic g);
        return $signed({~g, ~g, ~g, 1'b1});
    endfunction

    // Two Gray bits -> -3/-1/+1/+3: binary index b, level = 2b-3
    function automatic logic signed [3:0] lvl2(input logic [1:0] g);
        logic [1:0] b;
        b[1] = g[1];
        b[0] = b[1] ^ g[0];
        return $signed({~b[1], ~b[1], b[0], 1'b1});
    endfunction

    // Three Gray bits -> -7..+7 odd: binary index b, level = 2b-7
    function automatic logic signed [3:0] lvl3(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return $signed({~b[2], b[1:0], 1'b1});
    endfunction

    logic                en;
    logic signed [3:0]   lvl_i_c;
    logic signed [3:0]   lvl_q_c;
    int                  step_c;

    logic                v1;
    logic [1:0]          mode1;
    logic signed [3:0]   lvl_i1;
    logic signed [3:0]   lvl_q1;
    logic                last1;

    // Whole pipeline advances whenever the output register is free or drained
    assign en          = !bus.m_valid || bus.m_ready;
    assign bus.s_ready = en;

    // Gray decode of the incoming symbol according to its own mode
    always_comb begin
        lvl_i_c = '0;
        lvl_q_c = '0;
        unique case (bus.mode)
            2'd0: lvl_i_c = lvl1(bus.sym_in[0]);
            2'd1: begin
                lvl_i_c = lvl1(bus.sym_in[1]);
                lvl_q_c = lvl1(bus.sym_in[0]);
            end
            2'd2: begin
                lvl_i_c = lvl2(bus.sym_in[3:2]);
                lvl_q_c = lvl2(bus.sym_in[1:0]);
            end
            2'd3: begin
                lvl_i_c = lvl3(bus.sym_in[5:3]);
                lvl_q_c = lvl3(bus.sym_in[2:0]);
            end
        endcase
    end

    // Stage 1: captured mode, levels and frame flag
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= bus.s_valid;
            if (bus.s_valid) begin
                mode1  <= bus.mode;
                lvl_i1 <= lvl_i_c;
                lvl_q1 <= lvl_q_c;
                last1  <= bus.s_last;
            end
        end
    end

    // Amplitude step of the symbol held in stage 1
    always_comb begin
        step_c = 0;
        unique case (mode1)
            2'd0: step_c = STEP_BPSK;
            2'd1: step_c = STEP_QPSK;
            2'd2: step_c = STEP_16;
            2'd3: step_c = STEP_64;
        endcase
    end

    // Stage 2: scaled samples; data holds across bubbles so drains keep last value
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.out_r   <= '0;
            bus.out_i   <= '0;
        end else if (en) begin
            bus.m_valid <= v1;
            bus.m_last  <= v1 && last1;
            if (v1) begin
                bus.out_r <= OUT_W'(int'(lvl_i1) * step_c);
                bus.out_i <= OUT_W'(int'(lvl_q1) * step_c);
            end
        end
    end

    // Completed output handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt <= '0;
        end else if (bus.m_valid && bus.m_ready) begin
            sym_cnt <= sym_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_qam_mapper_multi.sv
// Self-checking bench for qam_mapper_multi: table-driven reference model,
// per-cycle compare process, directed scenarios and a randomized run.
module tb_qam_mapper_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sym_cnt;
    logic [3:0]  sym_cnt4;

    qam_mapper_multi_if #(.OUT_W(16)) bus ();
    qam_mapper_multi_if #(.OUT_W(16)) bus4 ();

    qam_mapper_multi #(.OUT_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .sym_cnt(sym_cnt)
    );

    // Narrow-counter instance fed with identical stimulus
    qam_mapper_multi #(.OUT_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave), .sym_cnt(sym_cnt4)
    );
    assign bus4.mode    = bus.mode;
    assign bus4.sym_in  = bus.sym_in;
    assign bus4.s_valid = bus.s_valid;
    assign bus4.s_last  = bus.s_last;
    assign bus4.m_ready = bus.m_ready;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int steps[4] = '{16384, 11585, 5181, 2528};
    int lv16[4]  = '{-3, -1, 3, 1};                  // index = 2-bit pattern
    int lv64[8]  = '{-7, -5, -1, -3, 7, 5, 1, 3};    // index = 3-bit pattern

    task automatic exp_iq(input int md, input int sy, output int r, output int i);
        int st;
        st = steps[md & 3];
        case (md & 3)
            0: begin r = ((sy & 1) != 0 ? 1 : -1) * st; i = 0; end
            1: begin
                r = ((sy & 2) != 0 ? 1 : -1) * st;
                i = ((sy & 1) != 0 ? 1 : -1) * st;
            end
            2: begin r = lv16[(sy >> 2) & 3] * st; i = lv16[sy & 3] * st; end
            default: begin r = lv64[(sy >> 3) & 7] * st; i = lv64[sy & 7] * st; end
        endcase
    endtask

    // Model state: stage-1 slot, output slot, handshake count
    bit v1 = 0, l1 = 0, mv = 0, ml = 0;
    int r1 = 0, i1 = 0, mr = 0, mi = 0, mcnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            v1 = 0; mv = 0; ml = 0; mr = 0; mi = 0; mcnt = 0;
        end else begin
            if (mv && bus.m_ready) mcnt = mcnt + 1;
            if (!mv || bus.m_ready) begin
                if (v1) begin mr = r1; mi = i1; end
                mv = v1;
                ml = v1 && l1;
                v1 = bus.s_valid;
                if (bus.s_valid) begin
                    exp_iq(int'(bus.mode), int'(bus.sym_in), r1, i1);
                    l1 = bus.s_last;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready", int'(bus.s_ready), int'(!mv || bus.m_ready));
            check("m_valid", int'(bus.m_valid), int'(mv));
            if (mv) check("m_last", int'(bus.m_last), int'(ml));
            check("out_r", int'(bus.out_r), mr);
            check("out_i", int'(bus.out_i), mi);
            check("sym_cnt", int'(sym_cnt), mcnt % 65536);
            check("sym_cnt4", int'(sym_cnt4), mcnt % 16);
        end
    end

    // ---------------- output collector ----------------
    typedef struct {
        int r;
        int i;
        bit last;
    } samp_t;
    samp_t got[$];
    bit    collect = 0;

    always @(negedge clk) begin
        if (collect && bus.m_valid && bus.m_ready)
            got.push_back('{int'(bus.out_r), int'(bus.out_i), bus.m_last});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one symbol and hold it until accepted
    task automatic push(input int md, input int sy, input bit last);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        bus.s_valid = 1'b1;
        bus.mode    = 2'(md);
        bus.sym_in  = 6'(sy);
        bus.s_last  = last;
        do begin
            @(negedge clk);
            acc = bus.s_ready;
            step_cyc();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (n) step_cyc();
    endtask

    int er, ei;
    int lit_md[4] = '{3, 0, 1, 2};
    int lit_sy[4] = '{6'b100011, 1, 2'b10, 0};
    int lit_r[4]  = '{17696, 16384, 11585, -15543};
    int lit_i[4]  = '{-7584, 0, -11585, -15543};

    initial begin
        bus.mode = 2'd0; bus.sym_in = 6'd0; bus.s_valid = 1'b0;
        bus.s_last = 1'b0; bus.m_ready = 1'b1;
        rst = 1'b1;
        step_cyc();
        chk_en = 1;
        step_cyc();
        // reset state
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_out_r", int'(bus.out_r), 0);
        check("rst_sym_cnt", int'(sym_cnt), 0);
        rst = 1'b0;
        step_cyc();

        // pin the model with hand-computed points
        exp_iq(2, 0, er, ei);
        check("model_16_r", er, -15543);
        check("model_16_i", ei, -15543);
        exp_iq(3, 6'b100011, er, ei);
        check("model_64_r", er, 17696);
        check("model_64_i", ei, -7584);
        exp_iq(2, 4'b1110, er, ei);
        check("model_16b_r", er, 5181);
        check("model_16b_i", ei, 15543);

        // 16-QAM sweep of all symbols
        got.delete(); collect = 1;
        for (int s = 0; s < 16; s++) push(2, s, 0);
        drain(4);
        check("sweep_count", got.size(), 16);
        for (int s = 0; s < 16 && s < got.size(); s++) begin
            exp_iq(2, s, er, ei);
            check("sweep_r", got[s].r, er);
            check("sweep_i", got[s].i, ei);
        end

        // back-to-back mode changes against literal samples
        got.delete();
        for (int k = 0; k < 4; k++) push(lit_md[k], lit_sy[k], 0);
        drain(4);
        check("lit_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("lit_r", got[k].r, lit_r[k]);
            check("lit_i", got[k].i, lit_i[k]);
        end

        // backpressure mid-stream
        got.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) push(1 + k % 3, (k * 7 + 3) % 64, 0);
            end
            begin
                repeat (3) step_cyc();
                bus.m_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_s_ready", int'(bus.s_ready), 0);
                    step_cyc();
                end
                bus.m_ready = 1'b1;
            end
        join
        drain(5);
        check("bp_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            exp_iq(1 + k % 3, (k * 7 + 3) % 64, er, ei);
            check("bp_r", got[k].r, er);
            check("bp_i", got[k].i, ei);
        end

        // frame end on the 5th of 5
        got.delete();
        for (int k = 0; k < 5; k++) push(3, k * 9, k == 4);
        drain(4);
        check("last_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            check("last_flag", int'(got[k].last), int'(k == 4));

        // reset with two symbols in flight
        bus.m_ready = 1'b0;
        push(2, 5, 0);
        push(2, 9, 1);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        step_cyc();
        @(negedge clk);
        check("flush_m_valid", int'(bus.m_valid), 0);
        check("flush_sym_cnt", int'(sym_cnt), 0);
        check("flush_out_r", int'(bus.out_r), 0);
        check("flush_out_i", int'(bus.out_i), 0);
        step_cyc();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        got.delete();
        drain(5);
        check("flush_presented", got.size(), 0);

        // counter wrap: 17 handshakes
        for (int k = 0; k < 17; k++) push(k % 4, k, 0);
        drain(4);
        check("wrap_cnt16", int'(sym_cnt), 17);
        check("wrap_cnt4", int'(sym_cnt4), 1);
        collect = 0;

        // randomized traffic with occasional reset
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            bus.s_valid  = ($urandom_range(0, 3) != 0);
            bus.mode     = 2'($urandom_range(0, 3));
            bus.sym_in   = 6'($urandom_range(0, 63));
            bus.s_last   = ($urandom_range(0, 7) == 0);
            bus.m_ready  = ($urandom_range(0, 2) != 0);
            step_cyc();
        end
        rst = 1'b0;
        bus.m_ready = 1'b1;
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
